// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave that fronts a word-organised SRAM. Each data phase can be
// stretched by a fixed number of wait states; bad transfers get a two-cycle ERROR.
module ahb_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          MEM_WORDS   = 256,
  parameter int          WAIT_STATES = 1
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        Hsel,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic        Hwrite,
  input  logic [2:0]  Hsize,
  input  logic [2:0]  Hburst,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  output logic        Hreadyout,
  output logic [1:0]  Hresp,
  output logic [31:0] Hrdata
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] WIN_BYTES = 32'(MEM_WORDS * 4);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_ERR1   = 3'd3;
  localparam logic [2:0] ST_ERR2   = 3'd4;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  logic [2:0]  state, state_nxt;
  logic [1:0]  wait_cnt, wait_cnt_nxt;
  logic [31:0] addr_q;
  logic        write_q;
  logic [2:0]  size_q;

  logic [31:0] mem [MEM_WORDS];

  // ---------------------------------------------------------------------------
  // Address phase decode
  // ---------------------------------------------------------------------------
  logic        phase_open;
  logic        accept;
  logic [31:0] addr_offset;
  logic        range_err, size_err, align_err, xfer_err;

  // A new address phase is only sampled when our own data phase is finishing.
  assign phase_open  = (state == ST_IDLE) || (state == ST_ACCESS) || (state == ST_ERR2);
  assign accept      = phase_open && Hsel && Hreadyin && Htrans[1];

  assign addr_offset = Haddr - BASE_ADDR;
  assign range_err   = (Haddr < BASE_ADDR) || (addr_offset >= WIN_BYTES);
  assign size_err    = (Hsize > 3'd2);
  assign align_err   = ((Hsize == 3'd1) && Haddr[0]) ||
                       ((Hsize == 3'd2) && (Haddr[1:0] != 2'b00));
  assign xfer_err    = range_err || size_err || align_err;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_WAIT: begin
        if (wait_cnt <= 2'd1) begin
          state_nxt    = ST_ACCESS;
          wait_cnt_nxt = 2'd0;
        end else begin
          wait_cnt_nxt = wait_cnt - 2'd1;
        end
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: begin
        // IDLE, ACCESS and ERR2 all decode the presented phase the same way;
        // unused encodings fall through here and recover to IDLE.
        if (!accept) begin
          state_nxt = ST_IDLE;
        end else if (xfer_err) begin
          state_nxt = ST_ERR1;
        end else if (WAIT_STATES > 0) begin
          state_nxt    = ST_WAIT;
          wait_cnt_nxt = 2'(WAIT_STATES);
        end else begin
          state_nxt = ST_ACCESS;
        end
      end
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state    <= ST_IDLE;
      wait_cnt <= 2'd0;
      addr_q   <= 32'd0;
      write_q  <= 1'b0;
      size_q   <= 3'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (accept) begin
        addr_q  <= Haddr;
        write_q <= Hwrite;
        size_q  <= Hsize;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory data phase
  // ---------------------------------------------------------------------------
  logic [31:0]   mem_offset;
  logic [AW-1:0] word_idx;
  logic [3:0]    byte_en;

  assign mem_offset = addr_q - BASE_ADDR;
  assign word_idx   = mem_offset[AW+1:2];

  always_comb begin
    byte_en = 4'b0000;
    case (size_q)
      3'd0:    byte_en = 4'b0001 << addr_q[1:0];
      3'd1:    byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // NOTE: the array has no reset branch; SRAM contents are meant to survive Hresetn.
  always_ff @(posedge Hclk) begin
    if ((state == ST_ACCESS) && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= Hwdata[8*b +: 8];
      end
    end
  end

  // Outputs depend on state only, so asserting Hresetn returns them to idle at once.
  assign Hreadyout = !((state == ST_WAIT) || (state == ST_ERR1));
  assign Hresp     = ((state == ST_ERR1) || (state == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
  assign Hrdata    = ((state == ST_ACCESS) && !write_q) ? mem[word_idx] : 32'd0;

  // Burst type and BUSY vs IDLE do not change behaviour; offset bits outside the index are don't-care.
  logic unused_ok;
  assign unused_ok = ^{Hburst, Htrans[0], mem_offset};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one instance with one wait state, one with none,
// driven from per-cycle vector tables plus a hand-written mid-transfer reset sequence.
module tb_ahb_sram_slave;

  localparam logic [31:0] B   = 32'h8000_0000;
  localparam logic [1:0]  IDL = 2'b00, BSY = 2'b01, NSQ = 2'b10, SQ = 2'b11;
  localparam logic [1:0]  OK  = 2'b00, ER = 2'b01;
  localparam logic [2:0]  SZB = 3'd0, SZH = 3'd1, SZW = 3'd2, SZX = 3'd3;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hri_lo;
    logic        exp_rdy;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel0, sel1, hri_lo, use_ws0;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [31:0] haddr, hwdata;
  logic        hreadyin;
  logic        rdy0, rdy1;
  logic [1:0]  resp0, resp1;
  logic [31:0] rdata0, rdata1;

  int n_cmp  = 0;
  int n_fail = 0;

  vec_t tbl1[$];
  vec_t tbl0[$];

  always #5 clk = ~clk;

  assign hreadyin = hri_lo ? 1'b0 : (use_ws0 ? rdy0 : rdy1);

  ahb_sram_slave #(.BASE_ADDR(B), .MEM_WORDS(256), .WAIT_STATES(1)) dut_ws1 (
    .Hclk(clk), .Hresetn(rst_n), .Hsel(sel1), .Hreadyin(hreadyin), .Htrans(htrans),
    .Hwrite(hwrite), .Hsize(hsize), .Hburst(hburst), .Haddr(haddr), .Hwdata(hwdata),
    .Hreadyout(rdy1), .Hresp(resp1), .Hrdata(rdata1)
  );

  ahb_sram_slave #(.BASE_ADDR(B), .MEM_WORDS(256), .WAIT_STATES(0)) dut_ws0 (
    .Hclk(clk), .Hresetn(rst_n), .Hsel(sel0), .Hreadyin(hreadyin), .Htrans(htrans),
    .Hwrite(hwrite), .Hsize(hsize), .Hburst(hburst), .Haddr(haddr), .Hwdata(hwdata),
    .Hreadyout(rdy0), .Hresp(resp0), .Hrdata(rdata0)
  );

  function automatic vec_t mk(input logic sel, input logic [1:0] trans, input logic write,
                              input logic [2:0] size, input logic [31:0] off,
                              input logic [31:0] wdata, input logic hlo, input logic rdy,
                              input logic [1:0] resp, input logic [31:0] rdata);
    vec_t v;
    v.sel = sel; v.trans = trans; v.write = write; v.size = size; v.addr = B + off;
    v.wdata = wdata; v.hri_lo = hlo; v.exp_rdy = rdy; v.exp_resp = resp; v.exp_rdata = rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input bit ws0);
    use_ws0 = ws0;
    sel1    = ws0 ? 1'b0 : v.sel;
    sel0    = ws0 ? v.sel : 1'b0;
    htrans  = v.trans;
    hwrite  = v.write;
    hsize   = v.size;
    haddr   = v.addr;
    hwdata  = v.wdata;
    hri_lo  = v.hri_lo;
    hburst  = ws0 ? 3'b011 : 3'b000;
  endtask

  // Called at a falling edge: check what the DUT shows this cycle, then present the row's inputs.
  task automatic run_row(input vec_t v, input bit ws0, input string tag, input int i);
    check($sformatf("%s[%0d].hreadyout", tag, i), {31'd0, ws0 ? rdy0 : rdy1}, {31'd0, v.exp_rdy});
    check($sformatf("%s[%0d].hresp", tag, i), {30'd0, ws0 ? resp0 : resp1}, {30'd0, v.exp_resp});
    check($sformatf("%s[%0d].hrdata", tag, i), ws0 ? rdata0 : rdata1, v.exp_rdata);
    drive(v, ws0);
    @(negedge clk);
  endtask

  initial begin
    // One wait state: write/read, byte lanes, error responses, non-transfers.
    tbl1.push_back(mk(1, NSQ, 1, SZW, 32'h10,  32'h0,         0, 1, OK, 32'h0));
    tbl1.push_back(mk(1, IDL, 0, SZW, 32'h10,  32'hDEAD_BEEF, 0, 0, OK, 32'h0));
    tbl1.push_back(mk(1, NSQ, 0, SZW, 32'h10,  32'hDEAD_BEEF, 0, 1, OK, 32'h0));
    tbl1.push_back(mk(1, IDL, 0, SZW, 32'h10,  32'h0,         0, 0, OK, 32'h0));
    tbl1.push_back(mk(1, NSQ, 1, SZW, 32'h20,  32'h0,         0, 1, OK, 32'hDEAD_BEEF));
    tbl1.push_back(mk(1, IDL, 0, SZW, 32'h20,  32'h0,         0, 0, OK, 32'h0));
    tbl1.push_back(mk(1, NSQ, 1, SZB, 32'h21,  32'h0,         0, 1, OK, 32'h0));
    tbl1.push_back(mk(1, IDL, 0, SZW, 32'h21,  32'h5555_AA55, 0, 0, OK, 32'h0));
    tbl1.push_back(mk(1, NSQ, 1, SZH, 32'h22,  32'h5555_AA55, 0, 1, OK, 32'h0));
    tbl1.push_back(mk(1, IDL, 0, SZW, 32'h22,  32'h1234_6666, 0, 0, OK, 32'h0));
    tbl1.push_back(mk(1, NSQ, 0, SZW, 32'h20,  32'h1234_6666, 0, 1, OK, 32'h0));
    tbl1.push_back(mk(1, IDL, 0, SZW, 32'h20,  32'h0,         0, 0, OK, 32'h0));
    tbl1.push_back(mk(1, NSQ, 0, SZW, 32'h02,  32'h0,         0, 1, OK, 32'h1234_AA00));
    tbl1.push_back(mk(1, IDL, 0, SZW, 32'h02,  32'h0,         0, 0, ER, 32'h0));
    tbl1.push_back(mk(1, NSQ, 0, SZW, 32'h400, 32'h0,         0, 1, ER, 32'h0));
    tbl1.push_back(mk(1, IDL, 0, SZW, 32'h400, 32'h0,         0, 0, ER, 32'h0));
    tbl1.push_back(mk(1, NSQ, 0, SZW, 32'h10,  32'h0,         0, 1, ER, 32'h0));
    tbl1.push_back(mk(1, IDL, 0, SZW, 32'h10,  32'h0,         0, 0, OK, 32'h0));
    tbl1.push_back(mk(1, NSQ, 1, SZX, 32'h30,  32'h0,         0, 1, OK, 32'hDEAD_BEEF));
    tbl1.push_back(mk(1, IDL, 0, SZW, 32'h30,  32'hFFFF_FFFF, 0, 0, ER, 32'h0));
    tbl1.push_back(mk(0, NSQ, 1, SZW, 32'h10,  32'hFFFF_FFFF, 0, 1, ER, 32'h0));
    tbl1.push_back(mk(1, NSQ, 1, SZW, 32'h10,  32'hBAD0_BAD0, 1, 1, OK, 32'h0));
    tbl1.push_back(mk(1, BSY, 1, SZW, 32'h10,  32'hBAD0_BAD0, 0, 1, OK, 32'h0));
    tbl1.push_back(mk(1, NSQ, 0, SZW, 32'h10,  32'hBAD0_BAD0, 0, 1, OK, 32'h0));
    tbl1.push_back(mk(1, IDL, 0, SZW, 32'h10,  32'h0,         0, 0, OK, 32'h0));
    tbl1.push_back(mk(1, IDL, 0, SZW, 32'h10,  32'h0,         0, 1, OK, 32'hDEAD_BEEF));
    tbl1.push_back(mk(1, IDL, 0, SZW, 32'h10,  32'h0,         0, 1, OK, 32'h0));

    // Zero wait states: INCR4 writes then reads with a BUSY, then read-after-write.
    tbl0.push_back(mk(1, NSQ, 1, SZW, 32'h40, 32'h0,         0, 1, OK, 32'h0));
    tbl0.push_back(mk(1, SQ,  1, SZW, 32'h44, 32'hA0A0_0001, 0, 1, OK, 32'h0));
    tbl0.push_back(mk(1, SQ,  1, SZW, 32'h48, 32'hA0A0_0002, 0, 1, OK, 32'h0));
    tbl0.push_back(mk(1, SQ,  1, SZW, 32'h4C, 32'hA0A0_0003, 0, 1, OK, 32'h0));
    tbl0.push_back(mk(1, NSQ, 0, SZW, 32'h40, 32'hA0A0_0004, 0, 1, OK, 32'h0));
    tbl0.push_back(mk(1, SQ,  0, SZW, 32'h44, 32'h0,         0, 1, OK, 32'hA0A0_0001));
    tbl0.push_back(mk(1, BSY, 0, SZW, 32'h48, 32'h0,         0, 1, OK, 32'hA0A0_0002));
    tbl0.push_back(mk(1, SQ,  0, SZW, 32'h48, 32'h0,         0, 1, OK, 32'h0));
    tbl0.push_back(mk(1, SQ,  0, SZW, 32'h4C, 32'h0,         0, 1, OK, 32'hA0A0_0003));
    tbl0.push_back(mk(1, IDL, 0, SZW, 32'h4C, 32'h0,         0, 1, OK, 32'hA0A0_0004));
    tbl0.push_back(mk(1, NSQ, 1, SZW, 32'h50, 32'h0,         0, 1, OK, 32'h0));
    tbl0.push_back(mk(1, NSQ, 0, SZW, 32'h50, 32'h5A5A_1234, 0, 1, OK, 32'h0));
    tbl0.push_back(mk(1, NSQ, 1, SZB, 32'h53, 32'h0,         0, 1, OK, 32'h5A5A_1234));
    tbl0.push_back(mk(1, NSQ, 0, SZW, 32'h50, 32'h7788_8888, 0, 1, OK, 32'h0));
    tbl0.push_back(mk(1, IDL, 0, SZW, 32'h50, 32'h0,         0, 1, OK, 32'h775A_1234));
    tbl0.push_back(mk(1, IDL, 0, SZW, 32'h50, 32'h0,         0, 1, OK, 32'h0));

    rst_n = 1'b0;
    drive(mk(0, IDL, 0, SZW, 32'h0, 32'h0, 0, 1, OK, 32'h0), 1'b0);
    repeat (2) @(negedge clk);
    check("reset.ws1.hreadyout", {31'd0, rdy1},  32'd1);
    check("reset.ws1.hresp",     {30'd0, resp1}, 32'd0);
    check("reset.ws1.hrdata",    rdata1,         32'd0);
    check("reset.ws0.hreadyout", {31'd0, rdy0},  32'd1);
    check("reset.ws0.hresp",     {30'd0, resp0}, 32'd0);
    check("reset.ws0.hrdata",    rdata0,         32'd0);

    // The first row meets the very first rising edge after release.
    rst_n = 1'b1;
    foreach (tbl1[i]) run_row(tbl1[i], 1'b0, "ws1", i);

    // Reset asserted while a write sits in its wait state.
    drive(mk(1, NSQ, 1, SZW, 32'h10, 32'h0, 0, 1, OK, 32'h0), 1'b0);
    @(negedge clk);
    check("rst_mid.wait_hreadyout", {31'd0, rdy1}, 32'd0);
    drive(mk(1, IDL, 0, SZW, 32'h10, 32'hCAFE_F00D, 0, 1, OK, 32'h0), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.hreadyout", {31'd0, rdy1},  32'd1);
    check("rst_mid.hresp",     {30'd0, resp1}, 32'd0);
    check("rst_mid.hrdata",    rdata1,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_row(mk(1, NSQ, 0, SZW, 32'h10, 32'h0, 0, 1, OK, 32'h0),         1'b0, "rst_rd", 0);
    run_row(mk(1, IDL, 0, SZW, 32'h10, 32'h0, 0, 0, OK, 32'h0),         1'b0, "rst_rd", 1);
    run_row(mk(1, IDL, 0, SZW, 32'h10, 32'h0, 0, 1, OK, 32'hDEAD_BEEF), 1'b0, "rst_rd", 2);
    run_row(mk(1, IDL, 0, SZW, 32'h10, 32'h0, 0, 1, OK, 32'h0),         1'b0, "rst_rd", 3);

    foreach (tbl0[i]) run_row(tbl0[i], 1'b1, "ws0", i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 Parameter BASE_ADDR, default 32'h8000_0000: base byte address of the memory window.
REQ-002 Parameter MEM_WORDS, default 256: depth in 32-bit words, power of two; window = MEM_WORDS*4 bytes.
REQ-003 Parameter WAIT_STATES, default 1: wait cycles inserted per OKAY data phase, range 0-3.
REQ-004 Port Hclk  input  1  clock; all state updates on rising edge.
REQ-005 Port Hresetn  input  1  reset; asynchronous assert, active-low.
REQ-006 Port Hsel  input  1  slave select from address decoder.
REQ-007 Port Hreadyin  input  1  bus-wide HREADY; address phase valid only when high.
REQ-008 Port Htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-009 Port Hwrite  input  1  1=write, 0=read.
REQ-010 Port Hsize  input  3  0=byte, 1=halfword, 2=word.
REQ-011 Port Hburst  input  3  burst type; accepted, no functional effect (each beat decoded independently).
REQ-012 Port Haddr  input  32  byte address.
REQ-013 Port Hwdata  input  32  write data, valid in data phase.
REQ-014 Port Hreadyout  output  1  0 = extend current data phase.
REQ-015 Port Hresp  output  2  OKAY=00, ERROR=01.
REQ-016 Port Hrdata  output  32  read data.

Function
REQ-017 Address phase accepted on a rising edge iff Hsel=1, Hreadyin=1, Htrans[1]=1; Haddr, Hwrite, Hsize captured into registers.
REQ-018 IDLE/BUSY or Hsel=0 with Hreadyin=1: no transfer; next data phase is zero-wait OKAY.
REQ-019 Error check on accepted phase: Hsize>2, halfword with Haddr[0]=1, word with Haddr[1:0]!=0, or Haddr outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*4-1].
REQ-020 FSM states: IDLE, WAIT, ACCESS, ERR1, ERR2.
REQ-021 IDLE: Hreadyout=1, Hresp=OKAY; accepted OK transfer -> WAIT if WAIT_STATES>0 else ACCESS; accepted error -> ERR1; else stay.
REQ-022 WAIT: Hreadyout=0, Hresp=OKAY; counter loaded with WAIT_STATES on entry, decrements each cycle; -> ACCESS when it reaches 1.
REQ-023 ACCESS: Hreadyout=1, Hresp=OKAY; transfer completes this cycle; new address phase accepted per REQ-017 (pipelined), next state chosen as from IDLE.
REQ-024 ERR1: Hreadyout=0, Hresp=ERROR; always -> ERR2; no memory access.
REQ-025 ERR2: Hreadyout=1, Hresp=ERROR; next state chosen as from IDLE on the phase presented.
REQ-026 Write: on the ACCESS edge, byte lanes enabled by captured Hsize and Haddr[1:0] (little-endian) loaded from the matching Hwdata lanes; other bytes unchanged.
REQ-027 Read: Hrdata = full word at captured address during ACCESS of a read, all 4 lanes driven; Hrdata=0 in every other cycle.
REQ-028 Word index = (captured Haddr - BASE_ADDR) >> 2, truncated to log2(MEM_WORDS) bits.
REQ-029 Read after write to same word in consecutive transfers returns newly written data (no stale read).
REQ-030 Memory array is not reset; contents persist across Hresetn.
REQ-031 Throughput with WAIT_STATES=0: one transfer per cycle, back-to-back.

Reset
REQ-032 Hresetn=0 immediately forces state IDLE, wait counter 0, captured-address registers 0, Hreadyout=1, Hresp=OKAY, Hrdata=0.
REQ-033 Reset mid-transfer (WAIT/ACCESS/ERR1/ERR2) aborts it; a write not yet in ACCESS edge leaves memory unchanged.
REQ-034 First address phase accepted on the first rising edge with Hresetn=1.

Verification
REQ-035 WAIT_STATES=1: word write 32'hDEAD_BEEF @BASE+0x10, then word read -> one Hreadyout=0 cycle each; Hrdata=32'hDEAD_BEEF, Hresp=OKAY.
REQ-036 Byte writes 8'hAA @+0x21, 16'h1234 halfword @+0x22 over word 0 -> word read @+0x20 = 32'h1234_AA00.
REQ-037 WAIT_STATES=0, INCR4 word writes @+0x40..+0x4C then INCR4 reads -> Hreadyout=1 all beats, data returned in order.
REQ-038 Word read @+0x02 and read @BASE+MEM_WORDS*4 -> each Hresp=ERROR for 2 cycles (Hreadyout 0 then 1), memory unchanged.
REQ-039 BUSY inserted mid-burst -> zero-wait OKAY, no access; burst resumes correctly.
REQ-040 Hresetn low during WAIT of a write -> outputs at reset values in same cycle; later read shows old data.
